gate_unit_arbiter: RTL and testbench

- Shares one bitwise two-operand logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) among `N_REQ` requesters.
- Round-robin arbitration, per-requester valid/ready handshake, and a single-entry registered result stage with its own valid/ready handshake.
- Sits between the requesting datapath blocks and the shared gate datapath.
- One operation is accepted per cycle when the result stage can take it.

---
 rtl/gate_pkg.sv | 20 ++
 rtl/gate_unit.sv | 38 +++
 rtl/gate_unit_arbiter.sv | 131 +++++++++++++
 tb/tb_gate_unit_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - opcode and result-stage state types for the shared gate unit
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } gate_op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/gate_unit.sv
// rtl/gate_unit.sv - combinational two-operand bitwise logic unit
//
// Ports:
//   op  : opcode (gate_op_t encoding)
//   x,y : operands, W bits (y ignored for NOT)
//   g   : result, W bits (zero for the reserved opcode)
//   err : high when op is the reserved opcode
module gate_unit
    import gate_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] g,
    output logic         err
);

    always_comb begin
        g   = '0;
        err = 1'b0;
        case (gate_op_t'(op))
            OP_AND:  g = x & y;
            OP_OR:   g = x | y;
            OP_NOT:  g = ~x;
            OP_NAND: g = ~(x & y);
            OP_NOR:  g = ~(x | y);
            OP_XOR:  g = x ^ y;
            OP_XNOR: g = ~(x ^ y);
            default: begin
                g   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// rtl/gate_unit_arbiter.sv - round-robin arbiter sharing one gate unit, with registered result stage
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid[N_REQ]      : per-requester operation pending
//   req_op[3*N_REQ]       : per-requester opcode, requester i in [3i+2:3i]
//   req_x/req_y[W*N_REQ]  : per-requester operands
//   req_ready[N_REQ]      : one-hot (or zero) accept
//   rsp_valid/rsp_ready   : result stage handshake
//   rsp_data, rsp_id, rsp_err : registered result, issuing requester, reserved-op flag
module gate_unit_arbiter
    import gate_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [3*N_REQ-1:0]         req_op,
    input  logic [W*N_REQ-1:0]         req_x,
    input  logic [W*N_REQ-1:0]         req_y,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    output logic [W-1:0]               rsp_data,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic                       rsp_err,
    input  logic                       rsp_ready
);

    localparam int IDW = $clog2(N_REQ);

    rsp_state_t     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] ptr_nxt;
    logic           any_valid;
    logic           slot_free;
    logic           grant;
    int             j;

    logic [2:0]     sel_op;
    logic [W-1:0]   sel_x;
    logic [W-1:0]   sel_y;
    logic [W-1:0]   g;
    logic           g_err;

    // Scan from the highest offset down so the requester closest to ptr
    // (lowest offset, with wrap) is the last assignment and wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        j         = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            cand = IDW'(j);
            if (req_valid[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign slot_free = (state == EMPTY) | rsp_ready;
    assign grant     = any_valid & slot_free & rst_n;
    assign ptr_nxt   = (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        req_ready = '0;
        sel_op    = '0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == IDW'(i)) begin
                req_ready[i] = grant;
                sel_op       = req_op[3*i +: 3];
                sel_x        = req_x[W*i +: W];
                sel_y        = req_y[W*i +: W];
            end
        end
    end

    gate_unit #(.W(W)) u_gate (
        .op  (sel_op),
        .x   (sel_x),
        .y   (sel_y),
        .g   (g),
        .err (g_err)
    );

    // Result payload holds its last value when the stage drains to EMPTY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            ptr       <= '0;
        end else begin
            if (grant) begin
                rsp_data <= g;
                rsp_id   <= winner;
                rsp_err  <= g_err;
                ptr      <= ptr_nxt;
            end
            case (state)
                EMPTY: begin
                    if (grant) begin
                        state     <= FULL;
                        rsp_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (rsp_ready && !grant) begin
                        state     <= EMPTY;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// tb/tb_gate_unit_arbiter.sv - self-checking bench for gate_unit_arbiter
module tb_gate_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_x;
    logic [W*N-1:0] req_y;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;
    logic           rsp_err;
    logic           rsp_ready;

    always #5 clk = ~clk;

    gate_unit_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit         m_full = 0;
    logic [7:0] m_data = 0;
    int         m_id   = 0;
    bit         m_err  = 0;
    int         m_ptr  = 0;
    int         last_grant = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-bit truth table: bit index {x,y} selects the output for that bit pair.
    function automatic logic [7:0] ref_gate(input int op, input logic [7:0] x, input logic [7:0] y);
        logic [3:0] tt;
        logic [7:0] r;
        case (op)
            0: tt = 4'b1000;
            1: tt = 4'b1110;
            2: tt = 4'b0011;
            3: tt = 4'b0111;
            4: tt = 4'b0001;
            5: tt = 4'b0110;
            6: tt = 4'b1001;
            default: tt = 4'b0000;
        endcase
        for (int b = 0; b < 8; b++) r[b] = tt[{x[b], y[b]}];
        return r;
    endfunction

    function automatic int ref_winner();
        if (!rst_n) return -1;
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input int op, input logic [7:0] x, input logic [7:0] y);
        req_valid[i]     = v;
        req_op[3*i +: 3] = 3'(op);
        req_x[W*i +: W]  = x;
        req_y[W*i +: W]  = y;
    endtask

    task automatic cycle(input string tag);
        int w;
        logic [N-1:0] er;
        #2;
        w  = ref_winner();
        er = (w < 0) ? '0 : (N'(1) << w);
        chk({tag, "_ready"}, 32'(req_ready), 32'(er));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_full = 0; m_data = 0; m_id = 0; m_err = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_full = 1;
            m_data = ref_gate(int'(req_op[3*w +: 3]), req_x[W*w +: W], req_y[W*w +: W]);
            m_id   = w;
            m_err  = (req_op[3*w +: 3] == 3'd7);
            m_ptr  = (w + 1) % N;
        end else if (rsp_ready) begin
            m_full = 0;
        end
        last_grant = w;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(m_full));
        chk({tag, "_data"},  32'(rsp_data),  32'(m_data));
        chk({tag, "_id"},    32'(rsp_id),    32'(m_id));
        chk({tag, "_err"},   32'(rsp_err),   32'(m_err));
    endtask

    initial begin
        logic [7:0] exp5 [8];
        logic [7:0] held_data;
        int rr_exp;

        exp5 = '{8'h0C, 8'h3F, 8'hF0, 8'hF3, 8'hC0, 8'h33, 8'hCC, 8'h00};

        // 1: reset with all requesters valid
        rst_n = 0; rsp_ready = 1; req_valid = '0; req_op = '0; req_x = '0; req_y = '0;
        for (int i = 0; i < N; i++) set_req(i, 1, i, 8'h11, 8'h22);
        cycle("t1_rst0");
        cycle("t1_rst1");
        chk("t1_valid", 32'(rsp_valid), 0);
        chk("t1_data", 32'(rsp_data), 0);

        // 2: single op from requester 2
        rst_n = 1;
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0);
        set_req(2, 1, 5, 8'hF0, 8'hAA);
        cycle("t2_op");
        chk("t2_data_const", 32'(rsp_data), 32'h5A);
        chk("t2_id_const", 32'(rsp_id), 2);
        set_req(2, 0, 0, 0, 0);
        cycle("t2_drain");

        // 3: round-robin, all requesters valid, no backpressure
        rst_n = 0;
        cycle("t3_rst");
        rst_n = 1;
        for (int i = 0; i < N; i++) set_req(i, 1, 5, 8'(i * 16 + 3), 8'h5C);
        for (int c = 0; c < 8; c++) begin
            cycle("t3_rr");
            rr_exp = c % N;
            chk("t3_seq_id", 32'(rsp_id), 32'(rr_exp));
            chk("t3_seq_valid", 32'(rsp_valid), 1);
        end

        // 4: backpressure while FULL with id 1
        rst_n = 0;
        cycle("t4_rst");
        rst_n = 1;
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0);
        set_req(1, 1, 1, 8'h81, 8'h18);
        cycle("t4_fill");
        set_req(1, 0, 0, 0, 0);
        set_req(3, 1, 6, 8'h3A, 8'hC5);
        rsp_ready = 0;
        held_data = rsp_data;
        for (int c = 0; c < 3; c++) begin
            cycle("t4_stall");
            chk("t4_stall_id", 32'(rsp_id), 1);
            chk("t4_stall_data", 32'(rsp_data), 32'(ref_gate(1, 8'h81, 8'h18)));
        end
        rsp_ready = 1;
        cycle("t4_release");
        chk("t4_release_grant", 32'(last_grant), 3);
        chk("t4_release_id", 32'(rsp_id), 3);
        set_req(3, 0, 0, 0, 0);

        // 5: opcode coverage on requester 0
        for (int op = 0; op < 8; op++) begin
            set_req(0, 1, op, 8'h0F, 8'h3C);
            cycle("t5_op");
            chk("t5_data_const", 32'(rsp_data), 32'(exp5[op]));
            chk("t5_err_const", 32'(rsp_err), (op == 7) ? 1 : 0);
        end
        set_req(0, 0, 0, 0, 0);

        // 6: reset mid-stream while FULL with ptr=2
        set_req(1, 1, 0, 8'hFF, 8'h0F);
        cycle("t6_fill");
        for (int i = 0; i < N; i++) set_req(i, 1, 4, 8'h55, 8'hAA);
        rst_n = 0;
        cycle("t6_rst");
        chk("t6_valid_after_rst", 32'(rsp_valid), 0);
        rst_n = 1;
        cycle("t6_first");
        chk("t6_first_id", 32'(rsp_id), 0);

        // Randomized phase: requesters hold their op while valid and not accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && last_grant != i))
                    set_req(i, $urandom_range(0, 1), $urandom_range(0, 7), 8'($urandom), 8'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 50) != 0);
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
